// File: rtl/joint_step_generator_if.sv
// Command handshake between the angle solver and the joint step generator.
// A solved joint pair (th1_in, th2_in) is offered with a one-cycle angles_valid
// pulse and is taken only while ready is high; valid pulses seen while ready is
// low are dropped, not queued. busy is high from accept until move completion.
interface joint_step_generator_if;
   logic signed [12:0] th1_in;
   logic signed [12:0] th2_in;
   logic               angles_valid;
   logic               ready;
   logic               busy;

   modport master (output th1_in, th2_in, angles_valid, input ready, busy);
   modport slave  (input th1_in, th2_in, angles_valid, output ready, busy);
endinterface

// File: rtl/joint_step_generator.sv
// Two-channel step/dir generator for a solved joint pair. Moves both joints from
// the tracked absolute position to the latched target on a shared step tick and
// pulses move_done when both have arrived.
// Optional feature: define JOINT_SOFT_LIMIT_EN to clamp targets to +/-TH_LIMIT
// at accept time and flag the clamp on limit_hit.
module joint_step_generator #(
   parameter int STEP_DIV  = 5000,
   parameter int PULSE_W   = 50,
   parameter int DIR_SETUP = 10,
   parameter int TH_LIMIT  = 2047
) (
   input  logic                      clk,
   input  logic                      reset,
   joint_step_generator_if.slave     cmd,
   output logic                      step1,
   output logic                      step2,
   output logic                      dir1,
   output logic                      dir2,
   output logic signed [12:0]        pos1,
   output logic signed [12:0]        pos2,
   output logic                      move_done,
   output logic                      limit_hit,
   output logic [2:0]                state_dbg
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DSETUP, S_STEP, S_DONE} state_t;

   // One counter serves both the dir setup wait and the step tick.
   localparam int              MAXC      = (STEP_DIV > DIR_SETUP) ? STEP_DIV : DIR_SETUP;
   localparam int              CW        = $clog2(MAXC + 1);
   localparam logic [CW-1:0]   TICK_LAST = CW'(STEP_DIV - 1);
   localparam logic [CW-1:0]   DS_LAST   = CW'(DIR_SETUP - 1);
   localparam logic [CW-1:0]   PW        = CW'(PULSE_W);

   state_t             state_q, state_d;
   logic [CW-1:0]      tick_q, tick_d;
   logic signed [12:0] tgt1_q, tgt1_d, tgt2_q, tgt2_d;
   logic signed [12:0] pos1_q, pos1_d, pos2_q, pos2_d;
   logic [13:0]        rem1_q, rem1_d, rem2_q, rem2_d;
   logic               dir1_q, dir1_d, dir2_q, dir2_d;
   logic               step1_q, step1_d, step2_q, step2_d;
   logic               move_done_q, move_done_d;
   logic signed [13:0] delta1, delta2;
   logic [13:0]        mag1, mag2;
   logic signed [12:0] new_tgt1, new_tgt2;
   logic               new_clamped;

   // Distance to target is formed one bit wider so it can never overflow.
   assign delta1 = {tgt1_q[12], tgt1_q} - {pos1_q[12], pos1_q};
   assign delta2 = {tgt2_q[12], tgt2_q} - {pos2_q[12], pos2_q};
   assign mag1   = delta1[13] ? (~delta1 + 14'sd1) : delta1;
   assign mag2   = delta2[13] ? (~delta2 + 14'sd1) : delta2;

`ifdef JOINT_SOFT_LIMIT_EN
   localparam logic signed [12:0] LIM = 13'(TH_LIMIT);
   logic limit_hit_q, limit_hit_d;

   // Clamp incoming targets into the soft joint window.
   always_comb begin
      new_tgt1    = cmd.th1_in;
      new_tgt2    = cmd.th2_in;
      new_clamped = 1'b0;
      if (cmd.th1_in > LIM) begin
         new_tgt1 = LIM;  new_clamped = 1'b1;
      end else if (cmd.th1_in < -LIM) begin
         new_tgt1 = -LIM; new_clamped = 1'b1;
      end
      if (cmd.th2_in > LIM) begin
         new_tgt2 = LIM;  new_clamped = 1'b1;
      end else if (cmd.th2_in < -LIM) begin
         new_tgt2 = -LIM; new_clamped = 1'b1;
      end
   end

   // limit_hit is refreshed on every accept and otherwise holds.
   always_comb begin
      limit_hit_d = limit_hit_q;
      if (state_q == S_IDLE && cmd.angles_valid) limit_hit_d = new_clamped;
   end

   // Limit flag register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) limit_hit_q <= 1'b0;
      else       limit_hit_q <= limit_hit_d;
   end

   assign limit_hit = limit_hit_q;
`else
   assign new_tgt1    = cmd.th1_in;
   assign new_tgt2    = cmd.th2_in;
   assign new_clamped = 1'b0;
   // TH_LIMIT has no effect without the soft limit; the flag stays low.
   assign limit_hit   = (TH_LIMIT >= 0) & new_clamped;
`endif

   // Sequencing: accept, compute distance, dir setup, stepping, completion.
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      tgt1_d      = tgt1_q;
      tgt2_d      = tgt2_q;
      pos1_d      = pos1_q;
      pos2_d      = pos2_q;
      rem1_d      = rem1_q;
      rem2_d      = rem2_q;
      dir1_d      = dir1_q;
      dir2_d      = dir2_q;
      step1_d     = 1'b0;
      step2_d     = 1'b0;
      move_done_d = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (cmd.angles_valid) begin
               tgt1_d  = new_tgt1;
               tgt2_d  = new_tgt2;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (mag1 == 14'd0 && mag2 == 14'd0) begin
               state_d = S_DONE;
            end else begin
               dir1_d  = ~delta1[13];
               dir2_d  = ~delta2[13];
               rem1_d  = mag1;
               rem2_d  = mag2;
               tick_d  = '0;
               state_d = S_DSETUP;
            end
         end
         S_DSETUP: begin
            if (tick_q == DS_LAST) begin
               tick_d  = '0;
               state_d = S_STEP;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         S_STEP: begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
            if (tick_q == '0) begin
               // Rising step edge: the position moves on this same cycle.
               if (rem1_q != 14'd0) begin
                  step1_d = 1'b1;
                  rem1_d  = rem1_q - 14'd1;
                  pos1_d  = dir1_q ? pos1_q + 13'sd1 : pos1_q - 13'sd1;
               end
               if (rem2_q != 14'd0) begin
                  step2_d = 1'b1;
                  rem2_d  = rem2_q - 14'd1;
                  pos2_d  = dir2_q ? pos2_q + 13'sd1 : pos2_q - 13'sd1;
               end
            end else if (tick_q < PW) begin
               step1_d = step1_q;
               step2_d = step2_q;
            end
            // Finish only once the last pulse period has fully elapsed.
            if (tick_q == TICK_LAST && rem1_q == 14'd0 && rem2_q == 14'd0) begin
               tick_d  = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset also forgets the position (re-home).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         tgt1_q      <= '0;
         tgt2_q      <= '0;
         pos1_q      <= '0;
         pos2_q      <= '0;
         rem1_q      <= '0;
         rem2_q      <= '0;
         dir1_q      <= 1'b0;
         dir2_q      <= 1'b0;
         step1_q     <= 1'b0;
         step2_q     <= 1'b0;
         move_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         tgt1_q      <= tgt1_d;
         tgt2_q      <= tgt2_d;
         pos1_q      <= pos1_d;
         pos2_q      <= pos2_d;
         rem1_q      <= rem1_d;
         rem2_q      <= rem2_d;
         dir1_q      <= dir1_d;
         dir2_q      <= dir2_d;
         step1_q     <= step1_d;
         step2_q     <= step2_d;
         move_done_q <= move_done_d;
      end
   end

   assign cmd.ready = (state_q == S_IDLE);
   assign cmd.busy  = (state_q != S_IDLE);
   assign step1     = step1_q;
   assign step2     = step2_q;
   assign dir1      = dir1_q;
   assign dir2      = dir2_q;
   assign pos1      = pos1_q;
   assign pos2      = pos2_q;
   assign move_done = move_done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_joint_step_generator.sv
// Bench for joint_step_generator: a model predicts each move's outcome when it
// is commanded; the prediction is queued and compared when move_done arrives.
module tb_joint_step_generator;
   localparam int STEP_DIV  = 8;
   localparam int PULSE_W   = 2;
   localparam int DIR_SETUP = 3;
   localparam int TH_LIMIT  = 4;
   localparam int BUDGET    = 2000;

   typedef struct packed {
      logic        lim;
      logic        dir1;
      logic        dir2;
      logic [15:0] lat;
      logic [15:0] first;
      logic [13:0] n1;
      logic [13:0] n2;
      logic [12:0] pos1;
      logic [12:0] pos2;
   } exp_t;
   localparam int EW = $bits(exp_t);

   logic               clk;
   logic               reset;
   logic               step1, step2, dir1, dir2, move_done, limit_hit;
   logic signed [12:0] pos1, pos2;
   logic [2:0]         state_dbg;

   joint_step_generator_if cmd_if ();

   joint_step_generator #(
      .STEP_DIV (STEP_DIV),
      .PULSE_W  (PULSE_W),
      .DIR_SETUP(DIR_SETUP),
      .TH_LIMIT (TH_LIMIT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd      (cmd_if),
      .step1    (step1),
      .step2    (step2),
      .dir1     (dir1),
      .dir2     (dir2),
      .pos1     (pos1),
      .pos2     (pos2),
      .move_done(move_done),
      .limit_hit(limit_hit),
      .state_dbg(state_dbg)
   );

   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int model_pos1 = 0;
   int model_pos2 = 0;
   logic model_dir1 = 1'b0;
   logic model_dir2 = 1'b0;

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int clamp_t(input int v, output logic hit);
      hit = 1'b0;
`ifdef JOINT_SOFT_LIMIT_EN
      if (v > TH_LIMIT) begin
         hit = 1'b1; return TH_LIMIT;
      end
      if (v < -TH_LIMIT) begin
         hit = 1'b1; return -TH_LIMIT;
      end
`endif
      return v;
   endfunction

   // Predict the outcome of a move and queue it.
   task automatic push_expect(input int t1, input int t2);
      exp_t e;
      logic h1, h2;
      int e1, e2, d1, d2, a1, a2, n;
      e1 = clamp_t(t1, h1);
      e2 = clamp_t(t2, h2);
      d1 = e1 - model_pos1;
      d2 = e2 - model_pos2;
      a1 = (d1 < 0) ? -d1 : d1;
      a2 = (d2 < 0) ? -d2 : d2;
      n  = (a1 > a2) ? a1 : a2;
      if (n != 0) begin
         model_dir1 = (d1 >= 0);
         model_dir2 = (d2 >= 0);
      end
      model_pos1 = e1;
      model_pos2 = e2;
      e.lim   = h1 | h2;
      e.dir1  = model_dir1;
      e.dir2  = model_dir2;
      e.lat   = 16'((n == 0) ? 2 : DIR_SETUP + 2 + n * STEP_DIV);
      e.first = 16'((n == 0) ? 0 : DIR_SETUP + 2);
      e.n1    = 14'(a1);
      e.n2    = 14'(a2);
      e.pos1  = 13'(e1);
      e.pos2  = 13'(e2);
      exp_q.push_back(e);
   endtask

   // Command a move, watch it to completion, then score it. inject_at > 0
   // pulses a stray command at that cycle, which must be ignored.
   task automatic run_move(input int t1, input int t2, input int inject_at);
      exp_t e;
      int cyc, first, c1, c2;
      logic p1, p2, done;
      push_expect(t1, t2);
      @(negedge clk);
      cmd_if.th1_in       = 13'(t1);
      cmd_if.th2_in       = 13'(t2);
      cmd_if.angles_valid = 1'b1;
      @(negedge clk);
      cmd_if.angles_valid = 1'b0;
      cyc = 0; first = 0; c1 = 0; c2 = 0; p1 = 1'b0; p2 = 1'b0; done = 1'b0;
      while (!done && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         cmd_if.angles_valid = 1'b0;
         if (cyc == 1) begin
            check("busy_during_move", int'(cmd_if.busy), 1);
            check("ready_during_move", int'(cmd_if.ready), 0);
         end
         if (step1 && !p1) begin
            c1++;
            if (first == 0) first = cyc;
         end
         if (step2 && !p2) begin
            c2++;
            if (first == 0) first = cyc;
         end
         p1 = step1;
         p2 = step2;
         if (inject_at > 0 && cyc == inject_at) begin
            cmd_if.th1_in       = 13'sd100;
            cmd_if.th2_in       = 13'sd100;
            cmd_if.angles_valid = 1'b1;
         end
         if (move_done) done = 1'b1;
      end
      e = exp_q.pop_front();
      if (!done) begin
         check("move_done_timeout", 0, 1);
      end else begin
         check("done_latency", cyc, int'(e.lat));
         check("first_step_cycle", first, int'(e.first));
         check("step1_count", c1, int'(e.n1));
         check("step2_count", c2, int'(e.n2));
         check("pos1", int'(pos1), int'($signed(e.pos1)));
         check("pos2", int'(pos2), int'($signed(e.pos2)));
         check("dir1", int'(dir1), int'(e.dir1));
         check("dir2", int'(dir2), int'(e.dir2));
         check("limit_hit", int'(limit_hit), int'(e.lim));
         @(negedge clk);
         check("move_done_one_cycle", int'(move_done), 0);
         check("ready_after_done", int'(cmd_if.ready), 1);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, int'(cmd_if.ready), 1);
      check({tag, "_busy"}, int'(cmd_if.busy), 0);
      check({tag, "_step1"}, int'(step1), 0);
      check({tag, "_step2"}, int'(step2), 0);
      check({tag, "_dir1"}, int'(dir1), 0);
      check({tag, "_dir2"}, int'(dir2), 0);
      check({tag, "_pos1"}, int'(pos1), 0);
      check({tag, "_pos2"}, int'(pos2), 0);
      check({tag, "_move_done"}, int'(move_done), 0);
      check({tag, "_limit_hit"}, int'(limit_hit), 0);
   endtask

   // Start a move, let two steps go out, then reset asynchronously.
   task automatic run_reset_mid_move(input int t1, input int t2);
      int cyc, c1;
      logic p1;
      @(negedge clk);
      cmd_if.th1_in       = 13'(t1);
      cmd_if.th2_in       = 13'(t2);
      cmd_if.angles_valid = 1'b1;
      @(negedge clk);
      cmd_if.angles_valid = 1'b0;
      cyc = 0; c1 = 0; p1 = 1'b0;
      while (c1 < 2 && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         if (step1 && !p1) c1++;
         p1 = step1;
      end
      check("reached_two_steps", c1, 2);
      #2 reset = 1'b1;
      #1;
      check_reset_values("mid_reset");
      model_pos1 = 0;
      model_pos2 = 0;
      model_dir1 = 1'b0;
      model_dir2 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int r1, r2;
      reset               = 1'b1;
      cmd_if.th1_in       = '0;
      cmd_if.th2_in       = '0;
      cmd_if.angles_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      @(negedge clk);

      run_move(5, -3, 0);
      run_move(5, -3, 0);
      run_move(0, 2, 10);
      run_move(10, -10, 0);
      run_move(1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         r1 = model_pos1 + int'($urandom_range(0, 12)) - 6;
         r2 = model_pos2 + int'($urandom_range(0, 12)) - 6;
         run_move(r1, r2, 0);
      end
      run_reset_mid_move(model_pos1 + 4, model_pos2 - 4);
      run_move(2, -1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end
endmodule
